// File: rtl/lavadora_pkg.sv
// Shared definitions for the washer phase sequencer: phase codes, latched
// service modes, default phase lengths and small helper functions.
package lavadora_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DRY   = 3'd5,
        PH_DONE  = 3'd6
    } fase_t;

    typedef enum logic [1:0] {
        MODO_NONE = 2'd0,
        MODO_SEC  = 2'd1,
        MODO_LAV  = 2'd2,
        MODO_PES  = 2'd3
    } modo_t;

    localparam int T_FILL_DEF  = 4;
    localparam int T_WASH_DEF  = 8;
    localparam int T_RINSE_DEF = 4;
    localparam int T_SPIN_DEF  = 3;
    localparam int T_DRY_DEF   = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Phase that follows a finished running phase; only heavy wash dries after spin.
    function automatic fase_t fase_siguiente(input fase_t f, input modo_t m);
        fase_t n;
        case (f)
            PH_FILL:  n = PH_WASH;
            PH_WASH:  n = PH_RINSE;
            PH_RINSE: n = PH_SPIN;
            PH_SPIN:  n = (m == MODO_PES) ? PH_DRY : PH_DONE;
            PH_DRY:   n = PH_DONE;
            default:  n = PH_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Loadable phase down-counter. Loading writes length-1; the count stops at
// zero and can be frozen with hold_i.
module temporizador_fase #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         hold_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over hold so a phase entry always restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/secuenciador_lavadora.sv
// Washer phase sequencer: accepts a single paid service on start, then walks
// FILL/WASH/RINSE/SPIN/DRY with per-phase timing, ending in a one-cycle DONE.
// Optional door pause is enabled by defining LAVADORA_PAUSA_PUERTA_EN.
//
// state    | meaning
// PH_IDLE  | waiting for start, mode flags evaluated
// PH_FILL  | water inlet
// PH_WASH  | drum turning, heater in heavy wash (double length)
// PH_RINSE | inlet and drum
// PH_SPIN  | drum at high speed
// PH_DRY   | drum and heater
// PH_DONE  | one-cycle completion pulse
module secuenciador_lavadora
    import lavadora_pkg::*;
#(
    parameter int T_FILL  = T_FILL_DEF,
    parameter int T_WASH  = T_WASH_DEF,
    parameter int T_RINSE = T_RINSE_DEF,
    parameter int T_SPIN  = T_SPIN_DEF,
    parameter int T_DRY   = T_DRY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       secado,
    input  logic       lavado,
    input  logic       lavado_pesado,
    input  logic       door_closed,
    output logic       valve_on,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       heater_on,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       start_err,
    output logic       paused
);

    // Floor of 2 keeps the counter at least one bit wide when every phase is 1 cycle.
    localparam int T_MAX = max_int(max_int(2 * T_WASH, T_FILL),
                                   max_int(max_int(T_RINSE, T_SPIN), max_int(T_DRY, 2)));
    localparam int TW    = $clog2(T_MAX);

    fase_t           state_q, state_d;
    modo_t           mode_q, mode_d;
    modo_t           mode_sel;
    logic            start_err_q, start_err_d;
    logic            paused_q;
    logic            start_ok;
    logic [1:0]      n_modes;
    logic            tmr_load;
    logic            tmr_zero;
    logic [TW-1:0]   tmr_value;

    function automatic logic [TW-1:0] fase_carga(input fase_t f, input modo_t m);
        int len;
        case (f)
            PH_FILL:  len = T_FILL;
            PH_WASH:  len = (m == MODO_PES) ? 2 * T_WASH : T_WASH;
            PH_RINSE: len = T_RINSE;
            PH_SPIN:  len = T_SPIN;
            PH_DRY:   len = T_DRY;
            default:  len = 1;
        endcase
        return TW'(len - 1);
    endfunction

    assign n_modes  = {1'b0, secado} + {1'b0, lavado} + {1'b0, lavado_pesado};
    assign start_ok = (n_modes == 2'd1) && door_closed;
    assign mode_sel = secado ? MODO_SEC : (lavado ? MODO_LAV : MODO_PES);

    // State, latched mode and reject pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PH_IDLE;
            mode_q      <= MODO_NONE;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            start_err_q <= start_err_d;
        end
    end

    // Next phase: start handling in IDLE, timer-driven advance otherwise.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        start_err_d = 1'b0;
        tmr_load    = 1'b0;
        case (state_q)
            PH_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        mode_d   = mode_sel;
                        state_d  = (mode_sel == MODO_SEC) ? PH_DRY : PH_FILL;
                        tmr_load = 1'b1;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            PH_DONE: state_d = PH_IDLE;
            default: begin
                if (!paused_q && tmr_zero) begin
                    state_d  = fase_siguiente(state_q, mode_q);
                    tmr_load = 1'b1;
                end
            end
        endcase
        tmr_value = fase_carga(state_d, mode_d);
    end

`ifdef LAVADORA_PAUSA_PUERTA_EN
    logic paused_d;

    // Pause only while a running phase is (still) active; DONE is never paused.
    always_comb begin
        paused_d = !door_closed && (state_d != PH_IDLE) && (state_d != PH_DONE);
    end

    // Registered so the pause starts and ends one cycle after the door moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_d;
        end
    end
`else
    assign paused_q = 1'b0;
`endif

    temporizador_fase #(
        .W (TW)
    ) u_temporizador (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .hold_i  (paused_q),
        .zero_o  (tmr_zero)
    );

    // Moore actuator decode from phase and latched mode, all off while paused.
    always_comb begin
        valve_on   = 1'b0;
        motor_on   = 1'b0;
        motor_fast = 1'b0;
        heater_on  = 1'b0;
        if (!paused_q) begin
            case (state_q)
                PH_FILL:  valve_on = 1'b1;
                PH_WASH: begin
                    motor_on  = 1'b1;
                    heater_on = (mode_q == MODO_PES);
                end
                PH_RINSE: begin
                    valve_on = 1'b1;
                    motor_on = 1'b1;
                end
                PH_SPIN: begin
                    motor_on   = 1'b1;
                    motor_fast = 1'b1;
                end
                PH_DRY: begin
                    motor_on  = 1'b1;
                    heater_on = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign phase     = state_q;
    assign busy      = (state_q != PH_IDLE);
    assign done      = (state_q == PH_DONE);
    assign start_err = start_err_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_secuenciador_lavadora.sv
// Bench for secuenciador_lavadora with default phase lengths: a vector table
// for start acceptance/reject/reset cases, then cycle-by-cycle program runs.
// Define LAVADORA_PAUSA_PUERTA_EN to also exercise the door pause.
module tb_secuenciador_lavadora;

    localparam int P_LAV = 0;
    localparam int P_PES = 1;
    localparam int P_SEC = 2;
    localparam int P_PAU = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       secado;
    logic       lavado;
    logic       lavado_pesado;
    logic       door_closed;
    logic       valve_on;
    logic       motor_on;
    logic       motor_fast;
    logic       heater_on;
    logic [2:0] phase;
    logic       busy;
    logic       done;
    logic       start_err;
    logic       paused;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      nm;
        logic       rst;
        logic       st;
        logic       sec;
        logic       lav;
        logic       pes;
        logic       door;
        logic [2:0] ph;
        logic       err;
        logic       bsy;
    } vec_t;

    vec_t vecs[15];

    secuenciador_lavadora dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .secado        (secado),
        .lavado        (lavado),
        .lavado_pesado (lavado_pesado),
        .door_closed   (door_closed),
        .valve_on      (valve_on),
        .motor_on      (motor_on),
        .motor_fast    (motor_fast),
        .heater_on     (heater_on),
        .phase         (phase),
        .busy          (busy),
        .done          (done),
        .start_err     (start_err),
        .paused        (paused)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int cyc, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {phase, valve_on, motor_on, motor_fast, heater_on, busy, done, start_err, paused};
    endfunction

    // Expected outputs from the phase/actuator table.
    function automatic logic [10:0] model(input int ph, input bit heavy, input bit pau);
        logic v, m, f, h;
        v = 1'b0; m = 1'b0; f = 1'b0; h = 1'b0;
        if (!pau) begin
            case (ph)
                1: v = 1'b1;
                2: begin m = 1'b1; h = heavy; end
                3: begin v = 1'b1; m = 1'b1; end
                4: begin m = 1'b1; f = 1'b1; end
                5: begin m = 1'b1; h = 1'b1; end
                default: ;
            endcase
        end
        return {3'(ph), v, m, f, h, (ph != 0), (ph == 6), 1'b0, pau};
    endfunction

    function automatic int ph_lav(input int c);
        if (c <= 4)  return 1;
        if (c <= 12) return 2;
        if (c <= 16) return 3;
        if (c <= 19) return 4;
        if (c == 20) return 6;
        return 0;
    endfunction

    // Phase timelines, cycle 1 being the first cycle after the accepted start.
    function automatic int exp_phase(input int prog, input int c);
        case (prog)
            P_LAV: return ph_lav(c);
            P_PES: begin
                if (c <= 4)  return 1;
                if (c <= 20) return 2;
                if (c <= 24) return 3;
                if (c <= 27) return 4;
                if (c <= 33) return 5;
                if (c == 34) return 6;
                return 0;
            end
            P_SEC: begin
                if (c <= 6) return 5;
                if (c == 7) return 6;
                return 0;
            end
            default: begin
                if (c <= 6)  return ph_lav(c);
                if (c <= 11) return 2;
                return ph_lav(c - 5);
            end
        endcase
    endfunction

    task automatic go(input logic s, input logic l, input logic p);
        secado        = s;
        lavado        = l;
        lavado_pesado = p;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        secado        = 1'b0;
        lavado        = 1'b0;
        lavado_pesado = 1'b0;
    endtask

    task automatic follow(input int prog, input int from_c, input int to_c, input string nm);
        bit pau;
        for (int c = from_c; c <= to_c; c++) begin
            pau = (prog == P_PAU) && (c >= 7) && (c <= 11);
            chk(nm, c, obs(), model(exp_phase(prog, c), prog == P_PES, pau));
            if (c < to_c) tick();
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; secado = 1'b0; lavado = 1'b0;
        lavado_pesado = 1'b0; door_closed = 1'b1;

        //          name              rst st sec lav pes door ph  err bsy
        vecs[0]  = '{"reset",          1, 0, 0, 0, 0, 1, 3'd0, 0, 0};
        vecs[1]  = '{"idle",           0, 0, 0, 0, 0, 1, 3'd0, 0, 0};
        vecs[2]  = '{"rej_sec_lav",    0, 1, 1, 1, 0, 1, 3'd0, 1, 0};
        vecs[3]  = '{"err_one_cycle",  0, 0, 0, 0, 0, 1, 3'd0, 0, 0};
        vecs[4]  = '{"rej_no_mode",    0, 1, 0, 0, 0, 1, 3'd0, 1, 0};
        vecs[5]  = '{"rej_door_open",  0, 1, 0, 1, 0, 0, 3'd0, 1, 0};
        vecs[6]  = '{"rej_all_modes",  0, 1, 1, 1, 1, 1, 3'd0, 1, 0};
        vecs[7]  = '{"rej_lav_pes",    0, 1, 0, 1, 1, 1, 3'd0, 1, 0};
        vecs[8]  = '{"reset_wins",     1, 1, 0, 1, 0, 1, 3'd0, 0, 0};
        vecs[9]  = '{"acc_sec",        0, 1, 1, 0, 0, 1, 3'd5, 0, 1};
        vecs[10] = '{"dry_running",    0, 0, 0, 0, 0, 1, 3'd5, 0, 1};
        vecs[11] = '{"busy_start_ign", 0, 1, 0, 1, 0, 1, 3'd5, 0, 1};
        vecs[12] = '{"reset_abort",    1, 0, 0, 0, 0, 1, 3'd0, 0, 0};
        vecs[13] = '{"acc_pes",        0, 1, 0, 0, 1, 1, 3'd1, 0, 1};
        vecs[14] = '{"reset_fill",     1, 0, 0, 0, 0, 1, 3'd0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            reset         = vecs[i].rst;
            start         = vecs[i].st;
            secado        = vecs[i].sec;
            lavado        = vecs[i].lav;
            lavado_pesado = vecs[i].pes;
            door_closed   = vecs[i].door;
            tick();
            reset = 1'b0; start = 1'b0; secado = 1'b0; lavado = 1'b0;
            lavado_pesado = 1'b0; door_closed = 1'b1;
            chk(vecs[i].nm, i, {6'b0, phase, start_err, busy},
                {6'b0, vecs[i].ph, vecs[i].err, vecs[i].bsy});
        end

        // Normal wash with a start attempt during WASH, then an immediate
        // dry-only start in the first IDLE cycle after DONE.
        go(1'b0, 1'b1, 1'b0);
        follow(P_LAV, 1, 7, "lav");
        secado = 1'b1;
        start  = 1'b1;
        tick();
        secado = 1'b0;
        start  = 1'b0;
        follow(P_LAV, 8, 21, "lav");
        go(1'b1, 1'b0, 1'b0);
        follow(P_SEC, 1, 8, "sec");

        // Heavy wash, with the door toggling mid-run (no pause in this build
        // unless the feature is compiled in, so keep the door closed here).
        go(1'b0, 1'b0, 1'b1);
        follow(P_PES, 1, 35, "pes");

        // Reset in RINSE aborts without a DONE pulse; a fresh start follows.
        go(1'b0, 1'b1, 1'b0);
        follow(P_LAV, 1, 14, "pre_rst");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_rinse", 15, obs(), model(0, 1'b0, 1'b0));
        tick();
        chk("rst_no_done", 16, obs(), model(0, 1'b0, 1'b0));
        go(1'b0, 1'b1, 1'b0);
        follow(P_LAV, 1, 5, "after_rst");
        reset = 1'b1;
        tick();
        reset = 1'b0;

`ifdef LAVADORA_PAUSA_PUERTA_EN
        // Door open while the edges ending cycles 6..10 are sampled: pause in
        // cycles 7..11, DONE moves from cycle 20 to cycle 25.
        go(1'b0, 1'b1, 1'b0);
        follow(P_PAU, 1, 6, "pau");
        door_closed = 1'b0;
        tick();
        follow(P_PAU, 7, 11, "pau");
        door_closed = 1'b1;
        tick();
        follow(P_PAU, 12, 26, "pau");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/secuenciador_lavadora.md
# secuenciador_lavadora

Phase sequencer for the coin-operated washer. It takes the paid service flags produced by the payment block (`secado`, `lavado`, `lavado_pesado`) plus a `start` strobe, then runs the matching program through timed phases: FILL, WASH, RINSE, SPIN, DRY. It drives the actuator enables (valve, motor, heater) and reports progress to the front panel. It sits between the payment block and the machine's actuator drivers.

## Interface
- `T_FILL`, default 4: FILL phase length in clk cycles (≥1)
- `T_WASH`, default 8: WASH phase length for normal wash (≥1); heavy wash uses 2×T_WASH
- `T_RINSE`, default 4: RINSE phase length (≥1)
- `T_SPIN`, default 3: SPIN phase length (≥1)
- `T_DRY`, default 6: DRY phase length (≥1)
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a program; sampled only in IDLE
- `secado`  in  1  dry-only service paid
- `lavado`  in  1  normal wash paid
- `lavado_pesado`  in  1  heavy wash paid
- `door_closed`  in  1  door interlock, 1 = closed
- `valve_on`  out  1  water inlet valve
- `motor_on`  out  1  drum motor
- `motor_fast`  out  1  high-speed motor (spin)
- `heater_on`  out  1  heater
- `phase`  out  3  current phase code
- `busy`  out  1  program running (phase ≠ IDLE)
- `done`  out  1  one-cycle pulse in DONE
- `start_err`  out  1  one-cycle pulse, start rejected
- `paused`  out  1  door pause active (0 when pause feature compiled out)

## Operation
- Phase codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DRY=5, DONE=6.
- Program selection on an accepted start:
  - `secado` selects DRY.
  - `lavado` selects FILL, WASH(T_WASH), RINSE, SPIN.
  - `lavado_pesado` selects FILL, WASH(2×T_WASH), RINSE, SPIN, DRY.
  - Every program ends in DONE, then IDLE.
- Mode latching:
  - Start is accepted only in IDLE, with exactly one mode flag high and `door_closed`=1.
  - The mode is latched internally at acceptance; mode inputs are ignored afterwards.
- Rejected start: in IDLE with zero or multiple modes, or with the door open, `start_err` pulses the next cycle and the block stays in IDLE.
- A start while busy is ignored silently.
- Phase timer:
  - Down-counter, loaded with length−1 on phase entry.
  - The phase advances when the counter reads 0, so each phase lasts exactly its length.
  - Width is ceil(log2(max(2×T_WASH, T_FILL, T_RINSE, T_SPIN, T_DRY))).
- Actuator outputs are Moore outputs, decoded from phase and latched mode:
  - FILL: valve_on.
  - WASH: motor_on, plus heater_on only in heavy wash.
  - RINSE: valve_on, motor_on.
  - SPIN: motor_on, motor_fast.
  - DRY: motor_on, heater_on.
  - IDLE and DONE: all actuators off.
- Reset:
  - All outputs go to 0, phase goes to IDLE, timer and latched mode are cleared.
  - Reset mid-program aborts immediately, with no DONE pulse.

## Timing
- Accepted start at edge k moves phase to the first phase in cycle k+1.
- DONE lasts exactly 1 cycle; IDLE follows, and `busy` is low from then on.
- `start_err` is asserted in cycle k+1 for a rejected start at edge k.
- A new start is accepted in the first IDLE cycle after DONE.
- Simultaneous reset and start: reset wins.

## Configuration
- `LAVADORA_PAUSA_PUERTA_EN` defined:
  - `door_closed`=0 during any running phase except DONE sets `paused`=1, forces all actuators off and freezes the timer.
  - Door closing clears `paused` the next cycle; the timer resumes from its frozen value, so total phase length is T plus the paused cycles.
- Not defined: `door_closed` is checked only at start; `paused` is tied to 0.

## Structure
- Shared package `lavadora_pkg`: phase code constants, mode encoding (SEC/LAV/PES), default phase-length constants.
- One sub-module, `temporizador_fase`: loadable down-counter with `load`, `value`, `hold` and `zero` flag. The FSM and output decode stay in `secuenciador_lavadora`.

## Test plan
All scenarios use default parameters.
- Normal wash: `lavado`=1, start at edge 0 → FILL cycles 1–4, WASH 5–12, RINSE 13–16, SPIN 17–19 (`motor_fast`=1), DONE 20 (`done`=1), IDLE 21.
- Heavy wash: `lavado_pesado`=1, start at edge 0 → WASH 5–20 with `heater_on`=1, SPIN 25–27, DRY 28–33, DONE 34.
- Dry only: `secado`=1, start at edge 0 → DRY 1–6, DONE 7; `valve_on` never 1.
- Invalid starts:
  - `lavado`=`secado`=1 with start → `start_err`=1 next cycle, phase stays 0.
  - Door open at start → same.
  - Start during WASH → no effect on the sequence.
- Reset asserted in RINSE → next cycle all outputs 0, phase=0, no `done` pulse; a fresh start is accepted afterwards.
- With `LAVADORA_PAUSA_PUERTA_EN`: door open for 5 cycles during WASH → `paused`=1 and actuators off for those cycles; DONE arrives 5 cycles later than nominal (cycle 25 for normal wash).
